axis_read_2d: RTL

//  AXI read master that fetches a 2-D block (rows x row_len words, row pitch = stride) from memory.

---
 rtl/axis_read_2d_pkg.sv | 24 ++
 rtl/axis_read_2d_addr.sv | 106 ++++++++++
 rtl/axis_read_2d.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_read_2d_pkg.sv
// Shared types and constants for the 2-D AXI block reader.
package axis_read_2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BASE   = 3'd1,
        ST_LEN    = 3'd2,
        ST_ROWS   = 3'd3,
        ST_STRIDE = 3'd4,
        ST_ACTIVE = 3'd5
    } cfg_state_e;

    localparam int unsigned PAGE_SHIFT = 12;
    localparam int unsigned PAGE_BYTES = 1 << PAGE_SHIFT;

    function automatic logic [31:0] min3_u32(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/axis_read_2d_addr.sv
// Row/burst address generator: splits rows at BURST_MAX and 4KB pages,
// gates requests on read-buffer credit and holds AR stable until accepted.
module axis_read_2d_addr
    import axis_read_2d_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned BEAT_BYTES = 32,
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [31:0]   beats_i,
    input  logic [31:0]   rows_i,
    input  logic [AW-1:0] stride_i,
    input  logic          pop_i,
    input  logic          arready_i,
    output logic [AW-1:0] araddr_o,
    output logic [7:0]    arlen_o,
    output logic          arvalid_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          run_q, run_d, arvalid_q, arvalid_d, load;
    logic [AW-1:0] row_addr_q, row_addr_d, cur_q, cur_d, araddr_q, araddr_d;
    logic [31:0]   beats_left_q, beats_left_d, rows_left_q, rows_left_d;
    logic [31:0]   burst, to_page;
    logic [7:0]    arlen_q, arlen_d;
    logic [CW-1:0] used_q, used_d;

    assign to_page = (32'(PAGE_BYTES) - 32'(cur_q[PAGE_SHIFT-1:0])) / 32'(BEAT_BYTES);
    assign burst   = min3_u32(beats_left_q, 32'(BURST_MAX), to_page);
    // used_q covers beats requested but not yet popped, so the FIFO cannot overflow
    assign load    = run_q && (!arvalid_q || arready_i) && (32'(used_q) + burst <= 32'(DEPTH));

    always_comb begin
        run_d        = run_q;
        row_addr_d   = row_addr_q;
        cur_d        = cur_q;
        beats_left_d = beats_left_q;
        rows_left_d  = rows_left_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        used_d       = used_q;
        if (pop_i && used_q != '0) used_d = used_q - CW'(1);
        if (arvalid_q && arready_i) arvalid_d = 1'b0;
        if (load) begin
            arvalid_d = 1'b1;
            araddr_d  = cur_q;
            arlen_d   = 8'(burst - 32'd1);
            used_d    = used_d + CW'(burst);
            if (beats_left_q == burst) begin
                if (rows_left_q == 32'd1) begin
                    run_d = 1'b0;
                end else begin
                    row_addr_d   = row_addr_q + stride_i;
                    cur_d        = row_addr_q + stride_i;
                    beats_left_d = beats_i;
                    rows_left_d  = rows_left_q - 32'd1;
                end
            end else begin
                cur_d        = cur_q + AW'(burst * 32'(BEAT_BYTES));
                beats_left_d = beats_left_q - burst;
            end
        end
        if (start_i) begin
            run_d        = (beats_i != '0) && (rows_i != '0);
            row_addr_d   = base_i;
            cur_d        = base_i;
            beats_left_d = beats_i;
            rows_left_d  = rows_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q        <= 1'b0;
            row_addr_q   <= '0;
            cur_q        <= '0;
            beats_left_q <= '0;
            rows_left_q  <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            used_q       <= '0;
        end else begin
            run_q        <= run_d;
            row_addr_q   <= row_addr_d;
            cur_q        <= cur_d;
            beats_left_q <= beats_left_d;
            rows_left_q  <= rows_left_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            used_q       <= used_d;
        end
    end

    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arvalid_o = arvalid_q;

endmodule

// File: rtl/axis_read_2d.sv
// 2-D AXI block reader: cfg-bus FSM, read-data FIFO and beat-to-word serializer
// emitting rows of DATA_WIDTH words with last on each row end.
module axis_read_2d
    import axis_read_2d_pkg::*;
#(
    parameter int unsigned BUF_AWIDTH     = 4,
    parameter int unsigned CONFIG_ID      = 1,
    parameter int unsigned CONFIG_ADDR    = 23,
    parameter int unsigned CONFIG_DATA    = 24,
    parameter int unsigned CONFIG_AWIDTH  = 5,
    parameter int unsigned CONFIG_DWIDTH  = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BURST_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_AWIDTH-1:0]  cfg_addr,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_data,
    input  logic                      cfg_valid,
    input  logic                      axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic                      axi_arvalid,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      last,
    output logic                      busy
);
    localparam int unsigned RATIO      = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = 1 << BUF_AWIDTH;
    localparam int unsigned CW         = BUF_AWIDTH + 1;
    localparam int unsigned LW         = $clog2(RATIO) + 1;
    localparam int unsigned AW         = AXI_ADDR_WIDTH;
    localparam int unsigned DW         = CONFIG_DWIDTH;

    cfg_state_e state_q, state_d;
    logic          id_hit, id_miss, cfg_wr, xfer_end;
    logic          busy_d, busy_q, start_d, start_q;
    logic [AW-1:0] base_q, stride_q;
    logic [DW-1:0] len_q, rows_q, len_m1;

    logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [BUF_AWIDTH-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      push, pop, rready_q;

    logic [AXI_DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [LW-1:0]             left_q, left_d;
    logic                      valid_q, valid_d, last_q, last_d;
    logic [DW-1:0]             cnt_q, cnt_d, row_q, row_d;

    assign id_hit   = cfg_valid && cfg_addr == CONFIG_AWIDTH'(CONFIG_ADDR)
                      && cfg_data == DW'(CONFIG_ID);
    assign id_miss  = cfg_valid && cfg_addr == CONFIG_AWIDTH'(CONFIG_ADDR)
                      && cfg_data != DW'(CONFIG_ID);
    assign cfg_wr   = cfg_valid && cfg_addr == CONFIG_AWIDTH'(CONFIG_DATA);
    assign len_m1   = len_q - DW'(1);
    assign xfer_end = (len_q == '0) || (rows_q == '0)
                      || (valid_q && ready && last_q && row_q == rows_q - DW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (id_hit) state_d = ST_BASE;
            ST_BASE:   if (id_miss) state_d = ST_IDLE; else if (cfg_wr) state_d = ST_LEN;
            ST_LEN:    if (id_miss) state_d = ST_IDLE; else if (cfg_wr) state_d = ST_ROWS;
            ST_ROWS:   if (id_miss) state_d = ST_IDLE; else if (cfg_wr) state_d = ST_STRIDE;
            ST_STRIDE: if (id_miss) state_d = ST_IDLE; else if (cfg_wr) state_d = ST_ACTIVE;
            ST_ACTIVE: if (xfer_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        start_d = (state_q == ST_STRIDE) && (state_d == ST_ACTIVE);
    end

    // Config capture; misaligned low bits are dropped here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            rows_q   <= '0;
            stride_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            start_q <= start_d;
            if (cfg_wr) begin
                case (state_q)
                    ST_BASE:   base_q   <= AW'(cfg_data) & ~AW'(BEAT_BYTES - 1);
                    ST_LEN:    len_q    <= cfg_data & ~DW'(RATIO - 1);
                    ST_ROWS:   rows_q   <= cfg_data;
                    ST_STRIDE: stride_q <= AW'(cfg_data) & ~AW'(BEAT_BYTES - 1);
                    default: ;
                endcase
            end
        end
    end

    axis_read_2d_addr #(
        .AW         (AW),
        .BEAT_BYTES (BEAT_BYTES),
        .BURST_MAX  (BURST_MAX),
        .DEPTH      (DEPTH)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_q),
        .base_i    (base_q),
        .beats_i   (32'(len_q / DW'(RATIO))),
        .rows_i    (32'(rows_q)),
        .stride_i  (stride_q),
        .pop_i     (pop),
        .arready_i (axi_arready),
        .araddr_o  (axi_araddr),
        .arlen_o   (axi_arlen),
        .arvalid_o (axi_arvalid)
    );

    // Beats arriving outside ACTIVE are stale (pre-reset) and are dropped
    assign push    = axi_rvalid && rready_q && (state_q == ST_ACTIVE);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= axi_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rready_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_q + BUF_AWIDTH'(push);
            rptr_q   <= rptr_q + BUF_AWIDTH'(pop);
            count_q  <= count_d;
            rready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Serializer: shift out LSB word first, reload from FIFO without a bubble
    always_comb begin
        sreg_d  = sreg_q;
        left_d  = left_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        pop     = 1'b0;
        if (valid_q && ready) begin
            if (cnt_q == len_m1) begin
                cnt_d = '0;
                row_d = row_q + DW'(1);
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
        if (!valid_q || ready) begin
            if (valid_q && left_q != LW'(1)) begin
                sreg_d = sreg_q >> DATA_WIDTH;
                left_d = left_q - LW'(1);
            end else if (count_q != '0) begin
                pop     = 1'b1;
                sreg_d  = mem_q[rptr_q];
                left_d  = LW'(RATIO);
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
        if (start_q) begin
            cnt_d = '0;
            row_d = '0;
        end
        last_d = valid_d && (cnt_d == len_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q  <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            sreg_q  <= sreg_d;
            left_q  <= left_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    assign axi_rready = rready_q;
    assign data       = sreg_q[DATA_WIDTH-1:0];
    assign valid      = valid_q;
    assign last       = last_q;
    assign busy       = busy_q;

endmodule
